// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: state enum, opcode/funct
// constants, ALU control codes and datapath mux selects.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_RTYPEWB = 4'd7,
      S_BRANCH  = 4'd8,
      S_IMMEX   = 4'd9,
      S_IMMWB   = 4'd10,
      S_JUMP    = 4'd11
   } state_t;

   // Which rule the ALU decoder applies in the current state
   typedef enum logic [1:0] {
      ALU_CLS_ADD   = 2'd0,
      ALU_CLS_SUB   = 2'd1,
      ALU_CLS_FUNCT = 2'd2,
      ALU_CLS_IMM   = 2'd3
   } alu_cls_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] SRCB_REGB    = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   // R-type funct codes the datapath can execute
   function automatic logic funct_legal(input logic [5:0] f);
      return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
             (f == FN_OR)  || (f == FN_SLT);
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU control decode: fixed add/sub, R-type funct lookup, or immediate-op lookup.
import mips_ctrl_pkg::*;

module alu_decoder (
   input  alu_cls_t    cls,
   input  logic [5:0]  op_code,
   input  logic [5:0]  funct,
   output logic [2:0]  alu_control
);

   // Select the ALU operation for the requested class
   always_comb begin
      alu_control = ALU_ADD;
      case (cls)
         ALU_CLS_ADD: alu_control = ALU_ADD;
         ALU_CLS_SUB: alu_control = ALU_SUB;
         ALU_CLS_FUNCT: begin
            case (funct)
               FN_SUB:  alu_control = ALU_SUB;
               FN_AND:  alu_control = ALU_AND;
               FN_OR:   alu_control = ALU_OR;
               FN_SLT:  alu_control = ALU_SLT;
               default: alu_control = ALU_ADD;
            endcase
         end
         ALU_CLS_IMM: begin
            case (op_code)
               OP_ANDI: alu_control = ALU_AND;
               OP_ORI:  alu_control = ALU_OR;
               default: alu_control = ALU_ADD;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore sequencer for the multicycle MIPS datapath. Outputs decode from the
// current state; only ir_write/pc_en/instr_done/illegal_op also look at
// mem_ready, alu_zero or the opcode. Write-type enables are masked while in reset.
import mips_ctrl_pkg::*;

module multicycle_control_unit (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op_code,
   input  logic [5:0] funct,
   input  logic       alu_zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       iord,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       memto_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_control,
   output logic       zero_extend,
   output logic [1:0] pc_src,
   output logic       pc_en,
   output logic       instr_done,
   output logic       illegal_op
);

   state_t     state_q, state_d;
   alu_cls_t   alu_cls;
   logic       alu_on;
   logic [2:0] dec_alu;
   logic       imm_zext;

   assign imm_zext = (op_code == OP_ANDI) || (op_code == OP_ORI);

   alu_decoder u_alu_dec (
      .cls         (alu_cls),
      .op_code     (op_code),
      .funct       (funct),
      .alu_control (dec_alu)
   );

   // States that do not use the ALU drive alu_control to 000
   assign alu_control = alu_on ? dec_alu : ALU_AND;

   // State register; reset returns straight to FETCH
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   // Next-state and output decode
   always_comb begin
      state_d     = state_q;
      mem_req     = 1'b0;
      iord        = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      reg_dst     = 1'b0;
      memto_reg   = 1'b0;
      reg_write   = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = SRCB_REGB;
      alu_on      = 1'b0;
      alu_cls     = ALU_CLS_ADD;
      zero_extend = 1'b0;
      pc_src      = PC_ALU;
      pc_en       = 1'b0;
      instr_done  = 1'b0;
      illegal_op  = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = SRCB_FOUR;
            alu_on    = 1'b1;
            ir_write  = mem_ready;
            pc_en     = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            // Branch target is computed here while the opcode is decoded
            alu_src_b = SRCB_IMM_SH2;
            alu_on    = 1'b1;
            case (op_code)
               OP_LW, OP_SW:           state_d = S_MEMADR;
               OP_BEQ, OP_BNE:         state_d = S_BRANCH;
               OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IMMEX;
               OP_J:                   state_d = S_JUMP;
               OP_RTYPE: begin
                  if (funct_legal(funct)) state_d = S_RTYPEEX;
                  else begin
                     state_d    = S_FETCH;
                     illegal_op = 1'b1;
                  end
               end
               default: begin
                  state_d    = S_FETCH;
                  illegal_op = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            alu_on    = 1'b1;
            state_d   = (op_code == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWR: begin
            mem_req    = 1'b1;
            iord       = 1'b1;
            mem_write  = 1'b1;
            instr_done = mem_ready;
            if (mem_ready) state_d = S_FETCH;
         end
         S_MEMWB: begin
            memto_reg  = 1'b1;
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_RTYPEEX: begin
            alu_src_a = 1'b1;
            alu_on    = 1'b1;
            alu_cls   = ALU_CLS_FUNCT;
            state_d   = S_RTYPEWB;
         end
         S_RTYPEWB: begin
            reg_dst    = 1'b1;
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a  = 1'b1;
            alu_on     = 1'b1;
            alu_cls    = ALU_CLS_SUB;
            pc_src     = PC_ALUOUT;
            pc_en      = (op_code == OP_BNE) ? !alu_zero : alu_zero;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_IMMEX: begin
            alu_src_a   = 1'b1;
            alu_src_b   = SRCB_IMM;
            alu_on      = 1'b1;
            alu_cls     = ALU_CLS_IMM;
            zero_extend = imm_zext;
            state_d     = S_IMMWB;
         end
         S_IMMWB: begin
            // ALU op and extension held so the result stays stable for writeback
            alu_on      = 1'b1;
            alu_cls     = ALU_CLS_IMM;
            zero_extend = imm_zext;
            reg_write   = 1'b1;
            instr_done  = 1'b1;
            state_d     = S_FETCH;
         end
         S_JUMP: begin
            pc_src     = PC_JUMP;
            pc_en      = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
      // No architectural side effects may escape while reset is held
      if (!rst_n) begin
         ir_write   = 1'b0;
         pc_en      = 1'b0;
         mem_write  = 1'b0;
         reg_write  = 1'b0;
         instr_done = 1'b0;
         illegal_op = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed instructions, then random ones,
// each checked cycle by cycle against a table-driven phase model.
module tb_multicycle_control_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] op_code, funct;
   logic       alu_zero, mem_ready;
   logic       mem_req, iord, mem_write, ir_write, reg_dst, memto_reg, reg_write;
   logic       alu_src_a, zero_extend, pc_en, instr_done, illegal_op;
   logic [1:0] alu_src_b, pc_src;
   logic [2:0] alu_control;

   int checks = 0;
   int fails  = 0;

   // Phases an instruction walks through
   localparam int K_FETCH = 0, K_DEC = 1, K_ADR = 2, K_RD = 3, K_MWB = 4, K_WR = 5,
                  K_REX = 6, K_RWB = 7, K_BR = 8, K_IEX = 9, K_IWB = 10, K_J = 11;

   // ir_write, pc_en, mem_write, reg_write, instr_done, illegal_op in the packed view
   localparam logic [18:0] EN_MASK = 19'h19007;

   logic [18:0] obs;
   assign obs = {mem_req, iord, mem_write, ir_write, reg_dst, memto_reg, reg_write,
                 alu_src_a, alu_src_b, alu_control, zero_extend, pc_src, pc_en,
                 instr_done, illegal_op};

   multicycle_control_unit dut (
      .clk(clk), .rst_n(rst_n), .op_code(op_code), .funct(funct),
      .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_req(mem_req), .iord(iord),
      .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
      .memto_reg(memto_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_control(alu_control), .zero_extend(zero_extend),
      .pc_src(pc_src), .pc_en(pc_en), .instr_done(instr_done), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
      if (op == 6'b000000)
         return fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
                fn == 6'b100101 || fn == 6'b101010;
      return op == 6'b100011 || op == 6'b101011 || op == 6'b000100 ||
             op == 6'b000101 || op == 6'b001000 || op == 6'b001100 ||
             op == 6'b001101 || op == 6'b000010;
   endfunction

   function automatic logic [2:0] rtype_alu(input logic [5:0] fn);
      case (fn)
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   // Expected output word for one cycle of a given phase
   function automatic logic [18:0] exp_out(input int k, input logic [5:0] op,
                                           input logic [5:0] fn, input logic z,
                                           input logic rdy);
      logic mreq, io, mw, irw, rdst, m2r, rw, sa, zx, pe, done, ill;
      logic [1:0] sb, ps;
      logic [2:0] ac, imm_ac;
      logic imm_zx;
      {mreq, io, mw, irw, rdst, m2r, rw, sa, zx, pe, done, ill} = '0;
      sb = 2'b00; ps = 2'b00; ac = 3'b000;
      imm_ac = (op == 6'b001100) ? 3'b000 : (op == 6'b001101) ? 3'b001 : 3'b010;
      imm_zx = (op == 6'b001100) || (op == 6'b001101);
      case (k)
         K_FETCH: begin mreq = 1; sb = 2'b01; ac = 3'b010; irw = rdy; pe = rdy; end
         K_DEC:   begin sb = 2'b11; ac = 3'b010; ill = !is_legal(op, fn); end
         K_ADR:   begin sa = 1; sb = 2'b10; ac = 3'b010; end
         K_RD:    begin mreq = 1; io = 1; end
         K_WR:    begin mreq = 1; io = 1; mw = 1; done = rdy; end
         K_MWB:   begin m2r = 1; rw = 1; done = 1; end
         K_REX:   begin sa = 1; ac = rtype_alu(fn); end
         K_RWB:   begin rdst = 1; rw = 1; done = 1; end
         K_BR:    begin sa = 1; ac = 3'b110; ps = 2'b01; done = 1;
                        pe = (op == 6'b000101) ? !z : z; end
         K_IEX:   begin sa = 1; sb = 2'b10; ac = imm_ac; zx = imm_zx; end
         K_IWB:   begin rw = 1; done = 1; ac = imm_ac; zx = imm_zx; end
         K_J:     begin ps = 2'b10; pe = 1; done = 1; end
         default: ;
      endcase
      return {mreq, io, mw, irw, rdst, m2r, rw, sa, sb, ac, zx, ps, pe, done, ill};
   endfunction

   task automatic check(input string tag, input logic [18:0] got, input logic [18:0] want);
      checks++;
      assert (got === want) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, want);
      end
   endtask

   // One clock of a phase: drive inputs, check mid-cycle, advance past the edge
   task automatic step(input int k, input logic rdy, input logic z, input string name);
      mem_ready = rdy;
      alu_zero  = (k == K_BR) ? z : 1'($urandom_range(0, 1));
      #2;
      check($sformatf("%s/ph%0d", name, k), obs, exp_out(k, op_code, funct, alu_zero, rdy));
      @(posedge clk);
      #1;
   endtask

   // Run one instruction; fw/mw are wait cycles in FETCH and in the data access
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int fw, input int mw, input string name);
      int plan[$];
      int waits;
      op_code = op;
      funct   = fn;
      plan.push_back(K_FETCH);
      plan.push_back(K_DEC);
      if (is_legal(op, fn)) begin
         case (op)
            6'b100011: begin plan.push_back(K_ADR); plan.push_back(K_RD); plan.push_back(K_MWB); end
            6'b101011: begin plan.push_back(K_ADR); plan.push_back(K_WR); end
            6'b000000: begin plan.push_back(K_REX); plan.push_back(K_RWB); end
            6'b000100, 6'b000101: plan.push_back(K_BR);
            6'b000010: plan.push_back(K_J);
            default:   begin plan.push_back(K_IEX); plan.push_back(K_IWB); end
         endcase
      end
      foreach (plan[i]) begin
         if (plan[i] == K_FETCH || plan[i] == K_RD || plan[i] == K_WR) begin
            waits = (plan[i] == K_FETCH) ? fw : mw;
            for (int w = 0; w <= waits; w++) step(plan[i], w == waits, z, name);
         end else begin
            step(plan[i], 1'($urandom_range(0, 1)), z, name);
         end
      end
   endtask

   initial begin
      logic [5:0] ops [10];
      logic [5:0] fns [5];
      logic [5:0] op, fn;
      ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
              6'b001000, 6'b001100, 6'b001101, 6'b000010, 6'b000000};
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

      rst_n = 1'b0; op_code = '0; funct = '0; alu_zero = 1'b0; mem_ready = 1'b1;
      #12;
      check("reset", obs, exp_out(K_FETCH, op_code, funct, 1'b0, 1'b1) & ~EN_MASK);
      rst_n = 1'b1;

      // Directed
      run_instr(6'b000000, 6'b100000, 1'b0, 0, 0, "add");
      run_instr(6'b100011, 6'b000000, 1'b0, 0, 2, "lw_wait");
      run_instr(6'b000100, 6'b000000, 1'b1, 0, 0, "beq_z1");
      run_instr(6'b000100, 6'b000000, 1'b0, 0, 0, "beq_z0");
      run_instr(6'b000101, 6'b000000, 1'b1, 0, 0, "bne_z1");
      run_instr(6'b000101, 6'b000000, 1'b0, 1, 0, "bne_z0");
      run_instr(6'b001101, 6'b000000, 1'b0, 0, 0, "ori");
      run_instr(6'b001100, 6'b000000, 1'b0, 0, 0, "andi");
      run_instr(6'b000010, 6'b000000, 1'b0, 0, 0, "j");
      run_instr(6'b111111, 6'b000000, 1'b0, 0, 0, "ill_op");
      run_instr(6'b000000, 6'b000000, 1'b0, 0, 0, "ill_fn");
      run_instr(6'b101011, 6'b000000, 1'b0, 2, 1, "sw");

      // Random
      for (int n = 0; n < 60; n++) begin
         op = ops[$urandom_range(0, 9)];
         fn = fns[$urandom_range(0, 4)];
         if ($urandom_range(0, 9) == 0) op = 6'($urandom);
         if (op == 6'b000000 && $urandom_range(0, 7) == 0) fn = 6'($urandom);
         run_instr(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                   $urandom_range(0, 3), "rand");
      end

      // sw abandoned by reset while the write is pending
      op_code = 6'b101011; funct = '0;
      step(K_FETCH, 1'b1, 1'b0, "sw_rst");
      step(K_DEC, 1'b1, 1'b0, "sw_rst");
      step(K_ADR, 1'b1, 1'b0, "sw_rst");
      mem_ready = 1'b0;
      #2;
      check("sw_rst_memwr", obs, exp_out(K_WR, op_code, funct, 1'b0, 1'b0));
      mem_ready = 1'b1;
      rst_n = 1'b0;
      #1;
      check("rst_async", obs, exp_out(K_FETCH, op_code, funct, 1'b0, 1'b1) & ~EN_MASK);
      @(posedge clk);
      #1;
      check("rst_held", obs, exp_out(K_FETCH, op_code, funct, 1'b0, 1'b1) & ~EN_MASK);
      rst_n = 1'b1;
      run_instr(6'b000000, 6'b101010, 1'b0, 0, 0, "slt_after_rst");
      step(K_FETCH, 1'b0, 1'b0, "final");

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multicycle sequencer for the MIPS datapath. It replaces the single-cycle combinational control path with a Moore state machine. The ALU, the unified instruction/data memory and the register file are shared across cycles. Each instruction runs over 3–5 states, and memory accesses are gated by a ready handshake. The block sits between the instruction register and the datapath muxes/enables, and drives every datapath control line.

## Interface
- No parameters; encodings fixed in package.
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op_code  in  6  instruction register [31:26].
- funct  in  6  instruction register [5:0].
- alu_zero  in  1  ALU zero flag, valid in BRANCH state.
- mem_ready  in  1  memory completed current access this cycle.
- mem_req  out  1  memory access requested.
- iord  out  1  address source: 0 = PC, 1 = ALU out register.
- mem_write  out  1  memory write enable.
- ir_write  out  1  instruction register load.
- reg_dst  out  1  write register: 0 = rt, 1 = rd.
- memto_reg  out  1  write data: 0 = ALU out, 1 = memory data register.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  0 = PC, 1 = reg A.
- alu_src_b  out  2  00 = reg B, 01 = constant 4, 10 = extended imm, 11 = extended imm << 2.
- alu_control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- zero_extend  out  1  immediate zero-extended instead of sign-extended.
- pc_src  out  2  00 = ALU result, 01 = ALU out register, 10 = jump target.
- pc_en  out  1  PC load enable.
- instr_done  out  1  one-cycle pulse in final state of each instruction.
- illegal_op  out  1  one-cycle pulse in DECODE on unsupported opcode/funct.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BRANCH, IMMEX, IMMWB, JUMP.
- Any output not listed for a state is 0.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_control=010, pc_src=00.
  - ir_write=pc_en=mem_ready.
  - Stay in FETCH while !mem_ready; go to DECODE when mem_ready.
- DECODE: alu_src_a=0, alu_src_b=11, alu_control=010 (branch target precomputed).
  - Next state by opcode:
    - 100011 (lw), 101011 (sw) -> MEMADR.
    - 000000 (R-type) -> RTYPEEX.
    - 000100 (beq), 000101 (bne) -> BRANCH.
    - 001000 (addi), 001100 (andi), 001101 (ori) -> IMMEX.
    - 000010 (j) -> JUMP.
    - Otherwise -> FETCH with illegal_op=1.
  - R-type with funct not in {100000, 100010, 100100, 100101, 101010} also -> FETCH with illegal_op=1.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_control=010; next MEMRD (lw) or MEMWR (sw).
- MEMRD: mem_req=1, iord=1; hold until mem_ready, then MEMWB.
- MEMWR: mem_req=1, iord=1, mem_write=1; hold until mem_ready, then FETCH with instr_done=1.
- MEMWB: reg_dst=0, memto_reg=1, reg_write=1, instr_done=1; next FETCH.
- RTYPEEX: alu_src_a=1, alu_src_b=00, alu_control from funct:
  - add 100000 -> 010; sub 100010 -> 110; and 100100 -> 000; or 100101 -> 001; slt 101010 -> 111.
  - Next RTYPEWB.
- RTYPEWB: reg_dst=1, reg_write=1, instr_done=1; next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_control=110, pc_src=01, instr_done=1; next FETCH.
  - pc_en=alu_zero for beq, !alu_zero for bne.
- IMMEX: alu_src_a=1, alu_src_b=10; next IMMWB.
  - addi: alu_control=010, zero_extend=0.
  - andi: alu_control=000, zero_extend=1.
  - ori: alu_control=001, zero_extend=1.
- IMMWB: reg_dst=0, reg_write=1, instr_done=1; hold zero_extend and alu_control from IMMEX; next FETCH.
- JUMP: pc_src=10, pc_en=1, instr_done=1; next FETCH.
- op_code and funct must be stable from DECODE until instruction end; the controller does not latch them.

## Timing
- Reset: state=FETCH asynchronously.
  - While rst_n=0: ir_write, pc_en, mem_write, reg_write, instr_done and illegal_op are forced to 0. The other outputs show FETCH values.
- All outputs are combinational from state. pc_en and ir_write also depend on mem_ready/alu_zero. No output register latency.
- Cycle counts with zero wait states: lw 5, sw 4, R-type 4, addi/andi/ori 4, beq/bne 3, j 3, illegal 2.
  - Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds 1.
- mem_req stays high and the address/control lines are held steady until the mem_ready cycle. The access completes on that edge.
- Reset asserted mid-instruction abandons it: no partial reg_write or mem_write after rst_n falls. The first FETCH follows rst_n deassertion.

## Structure
- Package mips_ctrl_pkg holds:
  - state enum (4-bit).
  - opcode and funct constants.
  - ALU control encodings.
  - alu_src_b and pc_src encodings.
- Sub-module alu_decoder: maps state class (add / sub / funct / imm-op) plus funct/op_code to alu_control; purely combinational.
- The top holds the state register, next-state logic and output decode.

## Test plan
- R-type add, op=000000, funct=100000, mem_ready tied 1 -> FETCH→DECODE→RTYPEEX→RTYPEWB; alu_control=010 in EX; reg_write=1, reg_dst=1 in WB; instr_done in cycle 4.
- lw (op=100011), mem_ready low 2 cycles in MEMRD -> MEMRD held 3 cycles with iord=1, mem_req=1; memto_reg=1, reg_write=1 in MEMWB; 7 cycles total.
- beq (op=000100) with alu_zero=1 -> pc_en=1, pc_src=01 in BRANCH. Same with alu_zero=0 -> pc_en=0. bne (000101) gives the inverse.
- ori (op=001101) -> zero_extend=1, alu_control=001 in IMMEX and IMMWB, reg_dst=0. j (000010) -> pc_src=10, pc_en=1, 3 cycles.
- op=111111, then R-type funct=000000 -> illegal_op pulse in DECODE, return to FETCH, no reg_write/mem_write asserted.
- sw (101011) with rst_n pulled low during MEMWR -> mem_write drops immediately, state=FETCH, all enables 0 until release.
